// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the 5-stage core pipeline control.
//   hz_state_t     : hazard controller FSM states
//   PCSRC_*        : encodings of the PC select coming from ID
//   BUB_W          : width of a bubble count (0..2 bubbles)
//   reg_hit()      : register-dependency test between a consumer and a producer
// ---------------------------------------------------------------------------
package pipe_pkg;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      STALL = 2'd1,
      MWAIT = 2'd2
   } hz_state_t;

   localparam logic [1:0] PCSRC_PLUS4  = 2'b00;
   localparam logic [1:0] PCSRC_PCIMM  = 2'b01;
   localparam logic [1:0] PCSRC_REGIMM = 2'b10;

   localparam int unsigned BUB_W = 2;

   localparam logic [BUB_W-1:0] BUB_ZERO = 2'd0;
   localparam logic [BUB_W-1:0] BUB_ONE  = 2'd1;
   localparam logic [BUB_W-1:0] BUB_TWO  = 2'd2;

   // A consumer register depends on a producer when it is actually read, is
   // not x0, and the producer writes that same register.
   function automatic logic reg_hit(input logic       use_i,
                                    input logic [4:0] rs_i,
                                    input logic       wr_i,
                                    input logic [4:0] rd_i);
      return use_i && (rs_i != 5'd0) && wr_i && (rd_i == rs_i);
   endfunction

endpackage

// File: rtl/hazard_detect.sv
// ---------------------------------------------------------------------------
// hazard_detect
// Combinational: number of bubbles the ID instruction needs right now.
// Ports:
//   rs1_i, rs2_i, useRs1_i, useRs2_i : ID source operands and their use
//   Branch_i, Ret_i                  : ID needs its operands in ID
//   rdEX_i, RegWriteEX_i, MemReadEX_i   : EX producer
//   rdMEM_i, RegWriteMEM_i, MemReadMEM_i: MEM producer
//   n_o                              : required bubble count (0, 1 or 2)
// ---------------------------------------------------------------------------
module hazard_detect
   import pipe_pkg::*;
(
   input  logic [4:0]       rs1_i,
   input  logic [4:0]       rs2_i,
   input  logic             useRs1_i,
   input  logic             useRs2_i,
   input  logic             Branch_i,
   input  logic             Ret_i,
   input  logic [4:0]       rdEX_i,
   input  logic             RegWriteEX_i,
   input  logic             MemReadEX_i,
   input  logic [4:0]       rdMEM_i,
   input  logic             RegWriteMEM_i,
   input  logic             MemReadMEM_i,
   output logic [BUB_W-1:0] n_o
);

   logic hit_ex_s;
   logic hit_mem_s;
   logic id_resolve_s;

   assign hit_ex_s  = reg_hit(useRs1_i, rs1_i, RegWriteEX_i, rdEX_i) ||
                      reg_hit(useRs2_i, rs2_i, RegWriteEX_i, rdEX_i);
   assign hit_mem_s = reg_hit(useRs1_i, rs1_i, RegWriteMEM_i, rdMEM_i) ||
                      reg_hit(useRs2_i, rs2_i, RegWriteMEM_i, rdMEM_i);
   assign id_resolve_s = Branch_i || Ret_i;

   // Bubble count in priority order. ALU results in MEM are forwarded, so
   // only a load in MEM stalls an ID-resolved branch.
   always_comb begin
      n_o = BUB_ZERO;
      if (id_resolve_s && hit_ex_s && MemReadEX_i) begin
         n_o = BUB_TWO;
      end else if (id_resolve_s && hit_ex_s) begin
         n_o = BUB_ONE;
      end else if (id_resolve_s && hit_mem_s && MemReadMEM_i) begin
         n_o = BUB_ONE;
      end else if (hit_ex_s && MemReadEX_i) begin
         n_o = BUB_ONE;
      end else begin
         n_o = BUB_ZERO;
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
// Pipeline advance/stall/bubble/flush controller for the 5-stage core.
// Ports:
//   clk_i, rst_n_i        : clock, synchronous active-low reset
//   rs*/useRs*/Branch/Ret : ID instruction operand info
//   IF_PCsrc_i            : PC select from ID (non-zero means redirect)
//   rd/RegWrite/MemRead EX, MEM : producers in EX and MEM
//   memBusy_i             : data memory wait, freezes everything
//   PCWrite_o, IFIDWrite_o, pipeWrite_o : register enables
//   controlZeroSel_o      : zero ID controls (bubble)
//   IFIDFlush_o           : clear IF/ID to a NOP
//   stallCnt_o, flushCnt_o: saturating bubble / flush counters
// Outputs are combinational from state and inputs so a hazard bubbles in the
// very cycle it is seen.
// ---------------------------------------------------------------------------
module hazard_ctrl
   import pipe_pkg::*;
#(
   parameter int unsigned CNT_W = 16
)(
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic [4:0]       rs1_i,
   input  logic [4:0]       rs2_i,
   input  logic             useRs1_i,
   input  logic             useRs2_i,
   input  logic             Branch_i,
   input  logic             Ret_i,
   input  logic [1:0]       IF_PCsrc_i,
   input  logic [4:0]       rdEX_i,
   input  logic             RegWriteEX_i,
   input  logic             MemReadEX_i,
   input  logic [4:0]       rdMEM_i,
   input  logic             RegWriteMEM_i,
   input  logic             MemReadMEM_i,
   input  logic             memBusy_i,
   output logic             PCWrite_o,
   output logic             IFIDWrite_o,
   output logic             pipeWrite_o,
   output logic             controlZeroSel_o,
   output logic             IFIDFlush_o,
   output logic [CNT_W-1:0] stallCnt_o,
   output logic [CNT_W-1:0] flushCnt_o
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   hz_state_t        state_q, state_d;
   hz_state_t        ret_q, ret_d;
   hz_state_t        act_state_s;
   logic [BUB_W-1:0] remain_q, remain_d;
   logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
   logic [BUB_W-1:0] n_s;
   logic             bubble_s;
   logic             advance_s;
   logic             flush_s;

   hazard_detect u_detect (
      .rs1_i         (rs1_i),
      .rs2_i         (rs2_i),
      .useRs1_i      (useRs1_i),
      .useRs2_i      (useRs2_i),
      .Branch_i      (Branch_i),
      .Ret_i         (Ret_i),
      .rdEX_i        (rdEX_i),
      .RegWriteEX_i  (RegWriteEX_i),
      .MemReadEX_i   (MemReadEX_i),
      .rdMEM_i       (rdMEM_i),
      .RegWriteMEM_i (RegWriteMEM_i),
      .MemReadMEM_i  (MemReadMEM_i),
      .n_o           (n_s)
   );

   // Next-state and cycle action (freeze / bubble / advance).
   always_comb begin
      state_d     = state_q;
      ret_d       = ret_q;
      remain_d    = remain_q;
      act_state_s = state_q;
      bubble_s    = 1'b0;
      advance_s   = 1'b0;
      flush_s     = 1'b0;
      if (!rst_n_i) begin
         state_d  = RUN;
         ret_d    = RUN;
         remain_d = BUB_ZERO;
      end else if (memBusy_i) begin
         // Freeze; remember where to resume unless already waiting.
         state_d = MWAIT;
         if (state_q != MWAIT) begin
            ret_d = state_q;
         end else begin
            ret_d = ret_q;
         end
      end else begin
         // Leaving MWAIT behaves exactly like the saved state would.
         if (state_q == MWAIT) begin
            act_state_s = ret_q;
         end else begin
            act_state_s = state_q;
         end
         case (act_state_s)
            STALL: begin
               bubble_s = 1'b1;
               remain_d = remain_q - BUB_ONE;
               if (remain_q == BUB_ONE) begin
                  state_d = RUN;
               end else begin
                  state_d = STALL;
               end
            end
            RUN: begin
               if (n_s != BUB_ZERO) begin
                  bubble_s = 1'b1;
                  if (n_s == BUB_TWO) begin
                     remain_d = BUB_ONE;
                     state_d  = STALL;
                  end else begin
                     state_d  = RUN;
                  end
               end else begin
                  advance_s = 1'b1;
                  flush_s   = (IF_PCsrc_i != PCSRC_PLUS4);
                  state_d   = RUN;
               end
            end
            default: begin
               state_d = RUN;
            end
         endcase
      end
   end

   // Output decode of the cycle action; reset forces a flushed, zeroed front end.
   always_comb begin
      PCWrite_o        = 1'b0;
      IFIDWrite_o      = 1'b0;
      pipeWrite_o      = 1'b0;
      controlZeroSel_o = 1'b0;
      IFIDFlush_o      = 1'b0;
      if (!rst_n_i) begin
         controlZeroSel_o = 1'b1;
         IFIDFlush_o      = 1'b1;
      end else if (bubble_s) begin
         pipeWrite_o      = 1'b1;
         controlZeroSel_o = 1'b1;
      end else if (advance_s) begin
         PCWrite_o   = 1'b1;
         IFIDWrite_o = 1'b1;
         pipeWrite_o = 1'b1;
         IFIDFlush_o = flush_s;
      end else begin
         PCWrite_o = 1'b0;
      end
   end

   // FSM state, pending bubble count and return state.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q  <= RUN;
         ret_q    <= RUN;
         remain_q <= BUB_ZERO;
      end else begin
         state_q  <= state_d;
         ret_q    <= ret_d;
         remain_q <= remain_d;
      end
   end

   // Saturating performance counters.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         stall_cnt_q <= {CNT_W{1'b0}};
         flush_cnt_q <= {CNT_W{1'b0}};
      end else begin
         if (bubble_s && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_q <= stall_cnt_q + CNT_ONE;
         end
         if (flush_s && (flush_cnt_q != CNT_MAX)) begin
            flush_cnt_q <= flush_cnt_q + CNT_ONE;
         end
      end
   end

   assign stallCnt_o = stall_cnt_q;
   assign flushCnt_o = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

   localparam int CNT_W = 8;
   localparam int MAXC  = (1 << CNT_W) - 1;

   typedef struct packed {
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       u1;
      logic       u2;
      logic       br;
      logic       ret;
      logic [1:0] pcsrc;
      logic [4:0] rdex;
      logic       rwex;
      logic       mrex;
      logic [4:0] rdmem;
      logic       rwmem;
      logic       mrmem;
      logic       busy;
   } in_t;

   typedef struct {
      in_t        in;
      logic [4:0] exp;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   in_t  cur;

   logic             PCWrite_o, IFIDWrite_o, pipeWrite_o, controlZeroSel_o, IFIDFlush_o;
   logic [CNT_W-1:0] stallCnt_o, flushCnt_o;

   int checks = 0;
   int errors = 0;

   // reference model state: bubbles still owed, counters
   int owed = 0;
   int scnt = 0;
   int fcnt = 0;

   always #5 clk = ~clk;

   hazard_ctrl #(.CNT_W(CNT_W)) dut (
      .clk_i            (clk),
      .rst_n_i          (rst_n),
      .rs1_i            (cur.rs1),
      .rs2_i            (cur.rs2),
      .useRs1_i         (cur.u1),
      .useRs2_i         (cur.u2),
      .Branch_i         (cur.br),
      .Ret_i            (cur.ret),
      .IF_PCsrc_i       (cur.pcsrc),
      .rdEX_i           (cur.rdex),
      .RegWriteEX_i     (cur.rwex),
      .MemReadEX_i      (cur.mrex),
      .rdMEM_i          (cur.rdmem),
      .RegWriteMEM_i    (cur.rwmem),
      .MemReadMEM_i     (cur.mrmem),
      .memBusy_i        (cur.busy),
      .PCWrite_o        (PCWrite_o),
      .IFIDWrite_o      (IFIDWrite_o),
      .pipeWrite_o      (pipeWrite_o),
      .controlZeroSel_o (controlZeroSel_o),
      .IFIDFlush_o      (IFIDFlush_o),
      .stallCnt_o       (stallCnt_o),
      .flushCnt_o       (flushCnt_o)
   );

   function automatic in_t vec(int rs1, int rs2, int u1, int u2, int br, int ret, int pcsrc,
                               int rdex, int rwex, int mrex, int rdmem, int rwmem, int mrmem,
                               int busy);
      in_t v;
      v.rs1 = 5'(rs1);   v.rs2 = 5'(rs2);
      v.u1 = 1'(u1);     v.u2 = 1'(u2);
      v.br = 1'(br);     v.ret = 1'(ret);
      v.pcsrc = 2'(pcsrc);
      v.rdex = 5'(rdex); v.rwex = 1'(rwex);   v.mrex = 1'(mrex);
      v.rdmem = 5'(rdmem); v.rwmem = 1'(rwmem); v.mrmem = 1'(mrmem);
      v.busy = 1'(busy);
      return v;
   endfunction

   // Bubbles required by the ID instruction, straight from the hazard rules.
   function automatic int model_n(in_t v);
      bit dep_ex, dep_mem, early;
      dep_ex  = (v.u1 && v.rs1 != 0 && v.rwex && v.rdex == v.rs1) ||
                (v.u2 && v.rs2 != 0 && v.rwex && v.rdex == v.rs2);
      dep_mem = (v.u1 && v.rs1 != 0 && v.rwmem && v.rdmem == v.rs1) ||
                (v.u2 && v.rs2 != 0 && v.rwmem && v.rdmem == v.rs2);
      early = v.br || v.ret;
      if (early && dep_ex && v.mrex) return 2;
      if (early && dep_ex) return 1;
      if (early && dep_mem && v.mrmem) return 1;
      if (dep_ex && v.mrex) return 1;
      return 0;
   endfunction

   // {PCWrite, IFIDWrite, pipeWrite, controlZeroSel, IFIDFlush}
   function automatic logic [4:0] model_ctl(in_t v, logic r, int ow);
      if (!r) return 5'b00011;
      if (v.busy) return 5'b00000;
      if (ow > 0) return 5'b00110;
      if (model_n(v) > 0) return 5'b00110;
      return {4'b1110, (v.pcsrc != 2'b00)};
   endfunction

   task automatic model_update();
      if (!rst_n) begin
         owed = 0; scnt = 0; fcnt = 0;
      end else if (cur.busy) begin
         owed = owed;
      end else if (owed > 0) begin
         owed = owed - 1;
         if (scnt < MAXC) scnt = scnt + 1;
      end else if (model_n(cur) > 0) begin
         owed = model_n(cur) - 1;
         if (scnt < MAXC) scnt = scnt + 1;
      end else if (cur.pcsrc != 2'b00) begin
         if (fcnt < MAXC) fcnt = fcnt + 1;
      end
   endtask

   // One clock: check outputs at the negedge, then advance the model.
   task automatic step(input bit use_exp, input logic [4:0] exp, input string name);
      logic [4:0] want, got;
      @(negedge clk);
      want = use_exp ? exp : model_ctl(cur, rst_n, owed);
      got  = {PCWrite_o, IFIDWrite_o, pipeWrite_o, controlZeroSel_o, IFIDFlush_o};
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s ctl got %b want %b", name, got, want);
      end
      checks++;
      if (stallCnt_o !== CNT_W'(scnt) || flushCnt_o !== CNT_W'(fcnt)) begin
         errors++;
         $display("FAIL %s cnt got stall=%0d flush=%0d want stall=%0d flush=%0d",
                  name, stallCnt_o, flushCnt_o, scnt, fcnt);
      end
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic chk_cnt(input string name, input int es, input int ef);
      checks++;
      if (stallCnt_o !== CNT_W'(es) || flushCnt_o !== CNT_W'(ef)) begin
         errors++;
         $display("FAIL %s got stall=%0d flush=%0d want stall=%0d flush=%0d",
                  name, stallCnt_o, flushCnt_o, es, ef);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      step(1'b1, 5'b00011, "reset_out");
      rst_n = 1'b1;
   endtask

   vec_t tbl[15];
   in_t  lw_beq, lw_beq2, lw_add, idle;

   initial begin
      cur = '0;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      model_update();
      #1;
      step(1'b1, 5'b00011, "reset_state");
      chk_cnt("reset_cnt", 0, 0);
      rst_n = 1'b1;

      tbl[0]  = '{vec(1,2,1,1,0,0,0, 3,1,0, 4,1,0, 0), 5'b11100};
      tbl[1]  = '{vec(1,2,1,1,0,0,1, 3,1,0, 4,1,0, 0), 5'b11101};
      tbl[2]  = '{vec(5,1,1,1,0,0,0, 5,1,1, 0,0,0, 0), 5'b00110};
      tbl[3]  = '{vec(1,5,1,1,0,0,0, 5,1,1, 0,0,0, 0), 5'b00110};
      tbl[4]  = '{vec(0,2,1,1,0,0,0, 0,1,1, 0,0,0, 0), 5'b11100};
      tbl[5]  = '{vec(7,1,1,1,0,0,0, 7,1,0, 0,0,0, 0), 5'b11100};
      tbl[6]  = '{vec(7,0,1,1,1,0,1, 7,1,0, 0,0,0, 0), 5'b00110};
      tbl[7]  = '{vec(9,0,1,0,0,1,2, 0,0,0, 9,1,1, 0), 5'b00110};
      tbl[8]  = '{vec(9,3,1,1,1,0,1, 0,0,0, 3,1,0, 0), 5'b11101};
      tbl[9]  = '{vec(5,1,0,1,0,0,0, 5,1,1, 0,0,0, 0), 5'b11100};
      tbl[10] = '{vec(5,1,1,1,0,0,0, 5,0,1, 0,0,0, 0), 5'b11100};
      tbl[11] = '{vec(1,2,1,1,0,1,2, 3,1,0, 0,0,0, 0), 5'b11101};
      tbl[12] = '{vec(5,1,1,1,0,0,0, 5,1,1, 0,0,0, 1), 5'b00000};
      tbl[13] = '{vec(1,2,1,1,0,0,3, 0,0,0, 0,0,0, 0), 5'b11101};
      tbl[14] = '{vec(6,2,1,0,1,0,1, 0,1,1, 6,1,0, 0), 5'b11101};
      for (int i = 0; i < 15; i++) begin
         cur = tbl[i].in;
         step(1'b1, tbl[i].exp, $sformatf("tbl%0d", i));
      end

      lw_beq  = vec(5,0,1,1,1,0,0, 5,1,1, 0,0,0, 0);
      lw_beq2 = vec(5,0,1,1,1,0,0, 0,0,0, 5,1,1, 0);
      lw_add  = vec(5,1,1,1,0,0,0, 5,1,1, 0,0,0, 0);
      idle    = vec(1,2,1,1,0,0,0, 0,0,0, 0,0,0, 0);

      // load-use: one bubble then advance
      do_reset();
      cur = lw_add;                               step(1'b1, 5'b00110, "A_bubble");
      cur = vec(5,1,1,1,0,0,0, 0,0,0, 5,1,1, 0);  step(1'b1, 5'b11100, "A_adv");
      chk_cnt("A_cnt", 1, 0);

      // load then branch: two bubbles then taken branch flushes
      do_reset();
      cur = lw_beq;  step(1'b1, 5'b00110, "B_b1");
      cur = lw_beq2; step(1'b1, 5'b00110, "B_b2");
      chk_cnt("B_stall", 2, 0);
      cur = vec(5,0,1,1,1,0,1, 0,0,0, 0,0,0, 0); step(1'b1, 5'b11101, "B_flush");
      chk_cnt("B_flushcnt", 2, 1);

      // ALU producer then jalr
      do_reset();
      cur = vec(7,0,1,0,0,1,2, 7,1,0, 0,0,0, 0); step(1'b1, 5'b00110, "C_bubble");
      cur = vec(7,0,1,0,0,1,2, 0,0,0, 7,1,0, 0); step(1'b1, 5'b11101, "C_flush");
      chk_cnt("C_cnt", 1, 1);

      // memory wait arriving while a bubble is still owed
      do_reset();
      cur = lw_beq; step(1'b1, 5'b00110, "D_b1");
      cur = lw_beq2; cur.busy = 1'b1;
      for (int i = 0; i < 3; i++) step(1'b1, 5'b00000, "D_freeze");
      cur.busy = 1'b0; step(1'b1, 5'b00110, "D_b2");
      cur = idle;      step(1'b1, 5'b11100, "D_adv");
      chk_cnt("D_cnt", 2, 0);

      // x0 never hazards; stall counter saturation
      do_reset();
      cur = vec(0,0,1,1,1,0,0, 0,1,1, 0,1,1, 0); step(1'b1, 5'b11100, "E_x0");
      cur = lw_add;
      for (int i = 0; i < MAXC + 5; i++) step(1'b0, 5'b00000, "E_sat");
      chk_cnt("E_sat_cnt", MAXC, 0);

      // reset mid-STALL and mid-MWAIT
      do_reset();
      cur = lw_beq; step(1'b1, 5'b00110, "F_b1");
      rst_n = 1'b0;
      step(1'b1, 5'b00011, "F_rst1");
      step(1'b1, 5'b00011, "F_rst2");
      rst_n = 1'b1;
      chk_cnt("F_cnt", 0, 0);
      cur = idle; step(1'b1, 5'b11100, "F_run");
      cur = lw_beq; step(1'b1, 5'b00110, "G_b1");
      cur.busy = 1'b1; step(1'b1, 5'b00000, "G_freeze");
      rst_n = 1'b0; step(1'b1, 5'b00011, "G_rst");
      rst_n = 1'b1;
      cur = idle; step(1'b1, 5'b11100, "G_run");

      // randomized against the reference model
      for (int i = 0; i < 3000; i++) begin
         rst_n = ($urandom_range(0, 99) != 0);
         cur = vec($urandom_range(0,3), $urandom_range(0,3), $urandom_range(0,1),
                   $urandom_range(0,1), $urandom_range(0,3) == 0, $urandom_range(0,5) == 0,
                   $urandom_range(0,3), $urandom_range(0,3), $urandom_range(0,1),
                   $urandom_range(0,1), $urandom_range(0,3), $urandom_range(0,1),
                   $urandom_range(0,1), $urandom_range(0,3) == 0);
         step(1'b0, 5'b00000, "rand");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
